// File: rtl/fadd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fadd_pipe
//  Description : Four-stage pipelined FloPoCo-format floating-point
//                adder/subtractor with valid tagging, sideband tag and stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module fadd_pipe #(
    parameter int WE    = 4,
    parameter int WF    = 4,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                in_valid,
    input  logic [WE+WF+2:0]    X,
    input  logic [WE+WF+2:0]    Y,
    input  logic                sub,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    output logic [WE+WF+2:0]    R,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int c_w   = WE + WF + 3;
    localparam int c_mw  = WF + 4;
    localparam int c_exw = WE + 8;
    localparam logic signed [c_exw-1:0] c_one  = c_exw'(1);
    localparam logic signed [c_exw-1:0] c_emax = c_exw'((1 << WE) - 1);

    // ------------------------------------------------------------------
    // S1: unpack, sign inversion, magnitude swap, exception classify
    // ------------------------------------------------------------------
    logic [1:0]    w_xn, w_yn;
    logic          w_xs, w_ys, w_swap, w_ex;
    logic [WE-1:0] w_xe, w_ye;
    logic [WF-1:0] w_xf, w_yf;
    logic [c_w-1:0] w_exw;

    assign w_xn   = X[c_w-1 -: 2];
    assign w_yn   = Y[c_w-1 -: 2];
    assign w_xs   = X[WE+WF];
    assign w_ys   = Y[WE+WF] ^ sub;
    assign w_xe   = X[WF +: WE];
    assign w_ye   = Y[WF +: WE];
    assign w_xf   = X[WF-1:0];
    assign w_yf   = Y[WF-1:0];
    assign w_swap = {w_ye, w_yf} > {w_xe, w_xf};

    always_comb begin
        w_ex  = 1'b1;
        w_exw = {2'b11, {(c_w-2){1'b0}}};
        if (w_xn == 2'b11 || w_yn == 2'b11) begin
            w_exw = {2'b11, {(c_w-2){1'b0}}};
        end else if (w_xn == 2'b10 && w_yn == 2'b10) begin
            if (w_xs == w_ys)
                w_exw = {2'b10, w_xs, {(c_w-3){1'b0}}};
        end else if (w_xn == 2'b10) begin
            w_exw = {2'b10, w_xs, {(c_w-3){1'b0}}};
        end else if (w_yn == 2'b10) begin
            w_exw = {2'b10, w_ys, {(c_w-3){1'b0}}};
        end else if (w_xn == 2'b00 && w_yn == 2'b00) begin
            w_exw = {2'b00, w_xs & w_ys, {(c_w-3){1'b0}}};
        end else if (w_xn == 2'b00) begin
            w_exw = {w_yn, w_ys, w_ye, w_yf};
        end else if (w_yn == 2'b00) begin
            w_exw = X;
        end else begin
            w_ex = 1'b0;
        end
    end

    logic [TAG_W-1:0] r1_tag;
    logic             r1_valid, r1_ex, r1_sa, r1_sb;
    logic [c_w-1:0]   r1_exw;
    logic [WE-1:0]    r1_ea, r1_diff;
    logic [WF-1:0]    r1_fa, r1_fb;

    // ------------------------------------------------------------------
    // S2: align the smaller mantissa, collect guard/round/sticky
    // ------------------------------------------------------------------
    logic [31:0]     w_sh;
    logic [c_mw-1:0] w_mbx, w_shifted, w_mb_al;
    logic            w_lost;

    assign w_sh      = (32'(r1_diff) > 32'(WF + 3)) ? 32'(WF + 3) : 32'(r1_diff);
    assign w_mbx     = {1'b1, r1_fb, 3'b000};
    assign w_shifted = w_mbx >> w_sh;
    assign w_lost    = |(w_mbx & ~({c_mw{1'b1}} << w_sh));
    assign w_mb_al   = {w_shifted[c_mw-1:1], w_shifted[0] | w_lost};

    logic [TAG_W-1:0] r2_tag;
    logic             r2_valid, r2_ex, r2_sa, r2_eff;
    logic [c_w-1:0]   r2_exw;
    logic [WE-1:0]    r2_ea;
    logic [c_mw-1:0]  r2_ma, r2_mb;

    // ------------------------------------------------------------------
    // S3: effective add/subtract and leading-zero count
    // ------------------------------------------------------------------
    logic [c_mw:0] w_sum;
    logic [7:0]    w_lzc;

    assign w_sum = r2_eff ? ({1'b0, r2_ma} - {1'b0, r2_mb})
                          : ({1'b0, r2_ma} + {1'b0, r2_mb});

    // Highest set bit wins because the scan runs upward.
    always_comb begin
        w_lzc = 8'(c_mw);
        for (int i = 0; i < c_mw; i++) begin
            if (w_sum[i])
                w_lzc = 8'(c_mw - 1 - i);
        end
    end

    logic [TAG_W-1:0] r3_tag;
    logic             r3_valid, r3_ex, r3_sign;
    logic [c_w-1:0]   r3_exw;
    logic [WE-1:0]    r3_ea;
    logic [c_mw:0]    r3_sum;
    logic [7:0]       r3_lzc;

    // ------------------------------------------------------------------
    // S4: normalise, round to nearest even, range check, pack
    // ------------------------------------------------------------------
    logic [c_mw-1:0]          w_mant;
    logic signed [c_exw-1:0]  w_exp, w_exp_r;
    logic                     w_rnd, w_fc;
    logic [WF-1:0]            w_frac;
    logic [c_w-1:0]           w_res;

    always_comb begin
        if (r3_sum[c_mw]) begin
            w_mant = {r3_sum[c_mw:2], r3_sum[1] | r3_sum[0]};
            w_exp  = $signed({8'd0, r3_ea}) + c_one;
        end else begin
            w_mant = r3_sum[c_mw-1:0] << r3_lzc;
            w_exp  = $signed({8'd0, r3_ea}) - $signed({{(c_exw-8){1'b0}}, r3_lzc});
        end
        w_rnd          = w_mant[2] & (w_mant[3] | w_mant[1] | w_mant[0]);
        {w_fc, w_frac} = {1'b0, w_mant[c_mw-2:3]} + {{WF{1'b0}}, w_rnd};
        w_exp_r        = w_fc ? (w_exp + c_one) : w_exp;

        // A normalised non-zero sum always has its top bit set.
        if (r3_ex)
            w_res = r3_exw;
        else if (!w_mant[c_mw-1])
            w_res = '0;
        else if (w_exp[c_exw-1])
            w_res = {2'b00, r3_sign, {(c_w-3){1'b0}}};
        else if (w_exp_r > c_emax)
            w_res = {2'b10, r3_sign, {(c_w-3){1'b0}}};
        else
            w_res = {2'b01, r3_sign, w_exp_r[WE-1:0], w_frac};
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            r3_valid  <= 1'b0;
            out_valid <= 1'b0;
            R         <= '0;
            out_tag   <= '0;
        end else if (ce) begin
            r1_valid  <= in_valid;
            r2_valid  <= r1_valid;
            r3_valid  <= r2_valid;
            out_valid <= r3_valid;
            if (r3_valid) begin
                R       <= w_res;
                out_tag <= r3_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            r1_tag  <= in_tag;
            r1_ex   <= w_ex;
            r1_exw  <= w_exw;
            r1_sa   <= w_swap ? w_ys : w_xs;
            r1_sb   <= w_swap ? w_xs : w_ys;
            r1_ea   <= w_swap ? w_ye : w_xe;
            r1_fa   <= w_swap ? w_yf : w_xf;
            r1_fb   <= w_swap ? w_xf : w_yf;
            r1_diff <= w_swap ? (w_ye - w_xe) : (w_xe - w_ye);

            r2_tag  <= r1_tag;
            r2_ex   <= r1_ex;
            r2_exw  <= r1_exw;
            r2_sa   <= r1_sa;
            r2_eff  <= r1_sa ^ r1_sb;
            r2_ea   <= r1_ea;
            r2_ma   <= {1'b1, r1_fa, 3'b000};
            r2_mb   <= w_mb_al;

            r3_tag  <= r2_tag;
            r3_ex   <= r2_ex;
            r3_exw  <= r2_exw;
            r3_sign <= r2_sa;
            r3_ea   <= r2_ea;
            r3_sum  <= w_sum;
            r3_lzc  <= w_lzc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fadd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fadd_pipe
//  Description : Self-checking bench for fadd_pipe (WE=4, WF=4) against an
//                exact-arithmetic reference model and an in-order result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fadd_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic [10:0] X = '0;
    logic [10:0] Y = '0;
    logic        sub = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic [10:0] R;
    logic [3:0]  out_tag;

    always #5 clk = ~clk;

    fadd_pipe #(.WE(4), .WF(4), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .X(X), .Y(Y), .sub(sub), .in_tag(in_tag),
        .out_valid(out_valid), .R(R), .out_tag(out_tag)
    );

    typedef struct {
        logic [10:0] r;
        logic [3:0]  t;
        int          age;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic        exp_ov = 1'b0;
    logic [10:0] exp_r  = '0;
    logic [3:0]  exp_t  = '0;

    localparam logic [10:0] NAN = 11'b11_0_0000_0000;

    // Reference: exact signed sum of integer mantissas, then RNE to 5 bits.
    function automatic logic [10:0] model(input logic [10:0] x, input logic [10:0] y, input logic s);
        logic [1:0] xn, yn;
        logic       xs, ys, rs;
        int         xe, ye, emin, p, sh, e;
        longint     sum, mag, qv, rem, half;
        xn = x[10:9]; yn = y[10:9];
        xs = x[8];    ys = y[8] ^ s;
        xe = int'(x[7:4]); ye = int'(y[7:4]);
        if (xn == 2'b11 || yn == 2'b11) return NAN;
        if (xn == 2'b10 && yn == 2'b10) return (xs == ys) ? {2'b10, xs, 8'd0} : NAN;
        if (xn == 2'b10) return {2'b10, xs, 8'd0};
        if (yn == 2'b10) return {2'b10, ys, 8'd0};
        if (xn == 2'b00 && yn == 2'b00) return {2'b00, xs & ys, 8'd0};
        if (xn == 2'b00) return {yn, ys, y[7:0]};
        if (yn == 2'b00) return x;
        emin = (xe < ye) ? xe : ye;
        sum  = (longint'(16 + int'(x[3:0])) << (xe - emin)) * (xs ? -1 : 1)
             + (longint'(16 + int'(y[3:0])) << (ye - emin)) * (ys ? -1 : 1);
        if (sum == 0) return 11'd0;
        rs  = (sum < 0);
        mag = rs ? -sum : sum;
        p = 0;
        for (int i = 0; i < 40; i++) if (mag[i]) p = i;
        sh = p - 4;
        e  = emin + sh;
        if (e < 0) return {2'b00, rs, 8'd0};
        if (sh > 0) begin
            qv   = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && qv[0])) qv = qv + 1;
            if (qv == 32) begin qv = 16; e = e + 1; end
        end else begin
            qv = mag << (-sh);
        end
        if (e > 15) return {2'b10, rs, 8'd0};
        return {2'b01, rs, e[3:0], qv[3:0]};
    endfunction

    function automatic logic [10:0] rnd_op();
        logic [10:0] v;
        int          k;
        v = 11'($urandom);
        k = int'($urandom_range(0, 15));
        if (k == 0)      v = {2'b00, v[8], 8'd0};
        else if (k == 1) v[10:9] = 2'b10;
        else if (k == 2) v[10:9] = 2'b11;
        else             v[10:9] = 2'b01;
        return v;
    endfunction

    task automatic step(input logic c, input logic v, input logic rst,
                        input logic [10:0] x, input logic [10:0] y, input logic s,
                        input logic [3:0] t, input logic [10:0] e);
        ce = c; in_valid = v; reset = rst;
        X = x; Y = y; sub = s; in_tag = t;
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_ov = 1'b0; exp_r = '0; exp_t = '0;
        end else if (c) begin
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            if (v) q.push_back('{r: e, t: t, age: 1});
            exp_ov = 1'b0;
            if (q.size() > 0 && q[0].age == 4) begin
                exp_ov = 1'b1; exp_r = q[0].r; exp_t = q[0].t;
                void'(q.pop_front());
            end
        end
        #1;
        checks++;
        assert (out_valid === exp_ov) else begin
            errors++;
            $error("FAIL out_valid got=%0b exp=%0b", out_valid, exp_ov);
        end
        checks++;
        assert (R === exp_r) else begin
            errors++;
            $error("FAIL R got=%b exp=%b (X=%b Y=%b sub=%0b)", R, exp_r, x, y, s);
        end
        checks++;
        assert (out_tag === exp_t) else begin
            errors++;
            $error("FAIL out_tag got=%0d exp=%0d", out_tag, exp_t);
        end
    endtask

    task automatic op(input logic [10:0] x, input logic [10:0] y, input logic s,
                      input logic [3:0] t, input logic [10:0] e);
        step(1'b1, 1'b1, 1'b0, x, y, s, t, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic drain_random();
        for (int k = 0; k < 100 && q.size() > 0; k++)
            step(1'($urandom), 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(4);
    endtask

    initial begin
        logic [10:0] x, y;
        logic        s, c;
        int          i;

        step(1'b1, 1'b0, 1'b1, '0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b1, '0, '0, 1'b0, '0, '0);

        // Directed cases with literal expected results
        op(11'b01_0_1000_0000, 11'b01_0_1000_1000, 1'b0, 4'd3, 11'b01_0_1001_0100);
        op(11'b01_0_1000_0000, 11'b01_0_1000_1000, 1'b1, 4'd4, 11'b01_1_0111_0000);
        op(11'b01_0_1000_1000, 11'b01_0_1000_1000, 1'b1, 4'd5, 11'b00_0_0000_0000);
        op(11'b01_0_0111_0000, 11'b01_0_0010_0000, 1'b0, 4'd6, 11'b01_0_0111_0000);
        op(11'b01_0_0111_0000, 11'b01_0_0010_1000, 1'b0, 4'd7, 11'b01_0_0111_0001);
        op(11'b01_0_1111_1111, 11'b01_0_1111_1111, 1'b0, 4'd8, 11'b10_0_0000_0000);
        op(11'b10_0_0000_0000, 11'b10_1_0000_0000, 1'b0, 4'd9, NAN);
        op(NAN,                11'b01_0_1000_0000, 1'b0, 4'd10, NAN);
        op(11'b00_0_0000_0000, 11'b01_0_1000_1000, 1'b1, 4'd11, 11'b01_1_1000_1000);
        op(11'b01_0_0000_0000, 11'b01_0_0000_0001, 1'b1, 4'd12, 11'b00_1_0000_0000);
        idle(5);

        // Eight back-to-back ops under a randomly toggling clock enable
        i = 0;
        for (int k = 0; k < 200 && i < 8; k++) begin
            c = 1'($urandom);
            x = rnd_op(); y = rnd_op(); s = 1'($urandom);
            step(c, 1'b1, 1'b0, x, y, s, 4'(i), model(x, y, s));
            if (c) i++;
        end
        drain_random();

        // Random traffic: bubbles, stalls, near-cancellation pairs
        for (int k = 0; k < 400; k++) begin
            x = rnd_op(); y = rnd_op(); s = 1'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                y = x; y[8] = ~x[8] ^ s; y[0] = 1'($urandom);
            end
            step(($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, x, y, s,
                 4'($urandom), model(x, y, s));
        end
        drain_random();

        // Mid-flight reset discards in-flight ops
        op(11'b01_0_1000_0000, 11'b01_0_1000_1000, 1'b0, 4'd1, 11'b01_0_1001_0100);
        op(11'b01_0_1000_0000, 11'b01_0_1000_0000, 1'b0, 4'd2, 11'b01_0_1001_0000);
        op(11'b01_0_0111_0000, 11'b01_0_0111_0000, 1'b1, 4'd3, 11'd0);
        step(1'b1, 1'b0, 1'b1, '0, '0, 1'b0, '0, '0);
        idle(5);
        op(11'b01_0_1000_0000, 11'b01_0_1000_1000, 1'b0, 4'd14, 11'b01_0_1001_0100);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
